// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: state encoding,
// nibble constants and a constant power-of-ten helper for the elaboration range check.
package bin_to_bcd_seq_pkg;

  localparam int unsigned NibW   = 4;
  localparam int unsigned AdjTh  = 5;
  localparam int unsigned AdjAdd = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StFin  = 2'd2
  } state_e;

  // 10^n as a 64-bit constant; saturates rather than wrapping for very large n.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] acc;
    acc = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      if (acc > 64'd1844674407370955161) begin
        acc = '1;
      end else begin
        acc = acc * 64'd10;
      end
    end
    return acc;
  endfunction

  // Largest value representable in w bits.
  function automatic logic [63:0] max_bin(input int unsigned w);
    logic [63:0] v;
    if (w >= 64) begin
      v = '1;
    end else begin
      v = (64'd1 << w) - 64'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake plus operand and BCD result bundle for bin_to_bcd_seq.
// The master side requests conversions; the slave side is the converter.
interface bin_to_bcd_seq_if
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned BinW   = 7,
  parameter int unsigned Digits = 3
) ();

  logic                   start;
  logic [BinW-1:0]        bin;
  logic                   busy;
  logic                   done;
  logic [NibW-1:0]        one;
  logic [NibW-1:0]        ten;
  logic [NibW-1:0]        hun;
  logic [NibW*Digits-1:0] bcd_all;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  one,
    input  ten,
    input  hun,
    input  bcd_all
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output one,
    output ten,
    output hun,
    output bcd_all
  );

endinterface

// File: rtl/bin_to_bcd_seq_dabble_adj.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bin_to_bcd_seq_dabble_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [NibW-1:0] nib_i,
  output logic [NibW-1:0] nib_o
);

  // 4-bit wrap is harmless: valid inputs never exceed 9 before adjustment.
  assign nib_o = (nib_i >= NibW'(AdjTh)) ? nib_i + NibW'(AdjAdd) : nib_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// A single bank of nibble adjusters is reused on every bit of the conversion.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned BinW   = 7,
  parameter int unsigned Digits = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bin_to_bcd_seq_if.slave    bus
);

  localparam int unsigned CntW = $clog2(BinW + 1);
  localparam int unsigned ScrW = NibW * Digits;
  localparam int unsigned CatW = ScrW + BinW;

  if (pow10(Digits) <= max_bin(BinW)) begin : g_range_err
    $error("bin_to_bcd_seq: Digits=%0d too few for BinW=%0d", Digits, BinW);
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q,   cnt_d;
  logic [BinW-1:0] bin_q,   bin_d;
  logic [ScrW-1:0] scr_q,   scr_d;
  logic [ScrW-1:0] res_q,   res_d;

  logic [ScrW-1:0] scr_adj;
  logic [CatW-1:0] cat_shifted;

  for (genvar d = 0; d < Digits; d++) begin : g_adj
    bin_to_bcd_seq_dabble_adj u_adj (
      .nib_i (scr_q[d*NibW +: NibW]),
      .nib_o (scr_adj[d*NibW +: NibW])
    );
  end

  // Adjust first, then shift the whole {scratch, operand} pair left by one.
  assign cat_shifted = {scr_adj[ScrW-2:0], bin_q, 1'b0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StConv;
          bin_d   = bus.bin;
          scr_d   = '0;
          cnt_d   = CntW'(BinW);
        end
      end
      StConv: begin
        {scr_d, bin_d} = cat_shifted;
        cnt_d          = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          res_d   = cat_shifted[CatW-1:BinW];
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      res_q   <= res_d;
    end
  end

  // Zero-extend so the fixed ones/tens/hundreds taps exist for any digit count.
  logic [ScrW+3*NibW-1:0] res_pad;
  assign res_pad = {{(3*NibW){1'b0}}, res_q};

  assign bus.busy    = (state_q == StConv);
  assign bus.done    = (state_q == StFin);
  assign bus.one     = res_pad[0*NibW +: NibW];
  assign bus.ten     = res_pad[1*NibW +: NibW];
  assign bus.hun     = res_pad[2*NibW +: NibW];
  assign bus.bcd_all = res_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq with default parameters (7-bit, 3 digits).
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BinW(7), .Digits(3)) bus ();

  bin_to_bcd_seq #(.BinW(7), .Digits(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents START for one edge; returns in cycle 1 of the conversion.
  task automatic start_conv(input logic [6:0] v);
    bus.start = 1'b1;
    bus.bin   = v;
    tick();
    bus.start = 1'b0;
  endtask

  // Called in cycle 1; returns the cycle index where DONE is first seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    tick();
    tick();
    total++;
    if ({bus.busy, bus.done, bus.bcd_all} !== 14'b0) begin
      bad++;
      $display("FAIL reset busy/done/bcd got %b/%b/%h want 0/0/000",
               bus.busy, bus.done, bus.bcd_all);
    end
    total++;
    if ({bus.hun, bus.ten, bus.one} !== 12'h000) begin
      bad++;
      $display("FAIL reset digits got %h/%h/%h want 0/0/0", bus.hun, bus.ten, bus.one);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    start_conv(7'd0);
    for (int c = 1; c <= 7; c++) begin
      total++;
      if ({bus.busy, bus.done} !== 2'b10) begin
        bad++;
        $display("FAIL zero_conv cycle %0d busy/done got %b/%b want 1/0", c, bus.busy, bus.done);
      end
      tick();
    end
    total++;
    if ({bus.busy, bus.done, bus.bcd_all} !== {2'b01, 12'h000}) begin
      bad++;
      $display("FAIL zero_fin busy/done/bcd got %b/%b/%h want 0/1/000",
               bus.busy, bus.done, bus.bcd_all);
    end
    tick();
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++;
      $display("FAIL zero_idle busy/done got %b/%b want 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_values();
    logic [6:0]  vin [3];
    logic [11:0] vexp[3];
    int          cyc;
    vin[0] = 7'd127; vexp[0] = 12'h127;
    vin[1] = 7'd99;  vexp[1] = 12'h099;
    vin[2] = 7'd100; vexp[2] = 12'h100;
    for (int i = 0; i < 3; i++) begin
      start_conv(vin[i]);
      wait_done(cyc);
      total++;
      if (cyc !== 8) begin
        bad++;
        $display("FAIL value_latency bin=%0d done cycle %0d want 8", vin[i], cyc);
      end
      total++;
      if ({bus.hun, bus.ten, bus.one} !== vexp[i] || bus.bcd_all !== vexp[i]) begin
        bad++;
        $display("FAIL value bin=%0d got %h/%h/%h all=%h want %h",
                 vin[i], bus.hun, bus.ten, bus.one, bus.bcd_all, vexp[i]);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int          ndone = 0;
    int          first = 0;
    logic [11:0] res   = '0;
    start_conv(7'd45);
    tick();
    tick();
    bus.start = 1'b1;
    bus.bin   = 7'd88;
    tick();
    bus.start = 1'b0;
    for (int c = 4; c <= 15; c++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (first == 0) first = c;
        res = bus.bcd_all;
      end
      tick();
    end
    total++;
    if (ndone !== 1 || first !== 8) begin
      bad++;
      $display("FAIL ignore_done count=%0d first=%0d want 1 at 8", ndone, first);
    end
    total++;
    if (res !== 12'h045) begin
      bad++;
      $display("FAIL ignore_result got %h want 045", res);
    end
  endtask

  task automatic test_rst_mid();
    int cyc;
    start_conv(7'd88);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    total++;
    if ({bus.busy, bus.done, bus.bcd_all} !== 14'b0) begin
      bad++;
      $display("FAIL rst_mid busy/done/bcd got %b/%b/%h want 0/0/000",
               bus.busy, bus.done, bus.bcd_all);
    end
    rst = 1'b0;
    start_conv(7'd63);
    wait_done(cyc);
    total++;
    if (cyc !== 8 || bus.bcd_all !== 12'h063) begin
      bad++;
      $display("FAIL rst_recover cycle=%0d bcd=%h want 8 063", cyc, bus.bcd_all);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int          ndone    = 0;
    int          d0       = 0;
    int          d1       = 0;
    logic [11:0] r0       = '0;
    logic [11:0] r1       = '0;
    int          unstable = 0;
    bus.start = 1'b1;
    bus.bin   = 7'd10;
    tick();
    bus.bin = 7'd11;
    for (int c = 1; c <= 30 && ndone < 2; c++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          d0 = c;
          r0 = bus.bcd_all;
        end else begin
          d1 = c;
          r1 = bus.bcd_all;
          bus.start = 1'b0;
        end
      end else if (ndone == 1 && bus.bcd_all !== r0) begin
        unstable++;
      end
      tick();
    end
    bus.start = 1'b0;
    total++;
    if (ndone !== 2 || d0 !== 8 || d1 - d0 !== 9) begin
      bad++;
      $display("FAIL b2b_timing dones=%0d at %0d,%0d want 2 at 8,17", ndone, d0, d1);
    end
    total++;
    if (r0 !== 12'h010 || r1 !== 12'h011) begin
      bad++;
      $display("FAIL b2b_result got %h,%h want 010,011", r0, r1);
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL b2b_hold %0d cycles changed between dones want 0", unstable);
    end
    tick();
  endtask

  task automatic test_sweep();
    int          cyc;
    logic [11:0] exp_bcd;
    for (int n = 0; n < 128; n++) begin
      exp_bcd = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
      start_conv(7'(n));
      wait_done(cyc);
      total++;
      if (cyc !== 8 || bus.bcd_all !== exp_bcd) begin
        bad++;
        $display("FAIL sweep n=%0d cycle=%0d bcd=%h want 8 %h", n, cyc, bus.bcd_all, exp_bcd);
      end
      tick();
      total++;
      if (bus.done !== 1'b0) begin
        bad++;
        $display("FAIL sweep_pulse n=%0d done=%b one cycle after want 0", n, bus.done);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    test_reset();
    test_zero();
    test_values();
    test_ignore_start();
    test_rst_mid();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
